// File: rtl/qpsk_wave_synth.sv
// QPSK carrier synthesis: holds a 4-bit phase code (x22.5 deg) for SPS samples and emits
// signed sine samples indexed by a free-running 16-step reference counter plus that phase.
module qpsk_wave_synth #(
  parameter int SPS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        phase_code,
  input  logic              phase_valid,
  output logic              phase_ready,
  output logic signed [7:0] sample_out,
  output logic              sample_valid,
  output logic              symbol_start,
  output logic              underrun,
  output logic              dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(SPS - 1);

  state_t            state_q;
  logic [3:0]        carrier_idx_q;
  logic [3:0]        held_phase_q;
  logic [7:0]        sym_cnt_q;
  logic signed [7:0] sample_out_q;
  logic              sample_valid_q;
  logic              symbol_start_q;
  logic              underrun_q;

  logic              transfer;
  logic [3:0]        phase_d;
  logic [3:0]        lut_idx_d;
  logic signed [7:0] sample_d;

  function automatic logic signed [7:0] sine_lut(input logic [3:0] k);
    logic signed [7:0] v;
    case (k)
      4'd0:    v = 8'sd0;
      4'd1:    v = 8'sd49;
      4'd2:    v = 8'sd90;
      4'd3:    v = 8'sd117;
      4'd4:    v = 8'sd127;
      4'd5:    v = 8'sd117;
      4'd6:    v = 8'sd90;
      4'd7:    v = 8'sd49;
      4'd8:    v = 8'sd0;
      4'd9:    v = -8'sd49;
      4'd10:   v = -8'sd90;
      4'd11:   v = -8'sd117;
      4'd12:   v = -8'sd127;
      4'd13:   v = -8'sd117;
      4'd14:   v = -8'sd90;
      default: v = -8'sd49;
    endcase
    return v;
  endfunction

  // Handshake: a code transfers on any edge where phase_valid && phase_ready. phase_ready
  // depends only on rst, state and sym_cnt (never on phase_valid); phase_code is ignored
  // on edges without a transfer.
  always_comb begin
    phase_ready = 1'b0;
    if (!rst || state_q == IDLE || sym_cnt_q == LAST_CNT) phase_ready = 1'b1;
  end

  // A newly accepted code drives the sample on the same edge it is accepted.
  always_comb begin
    transfer  = rst && phase_valid && phase_ready;
    phase_d   = transfer ? phase_code : held_phase_q;
    lut_idx_d = carrier_idx_q + phase_d;
    sample_d  = sine_lut(lut_idx_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      carrier_idx_q  <= 4'd0;
      held_phase_q   <= 4'd0;
      sym_cnt_q      <= 8'd0;
      sample_out_q   <= 8'sd0;
      sample_valid_q <= 1'b0;
      symbol_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      carrier_idx_q  <= carrier_idx_q + 4'd1;
      symbol_start_q <= 1'b0;
      underrun_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          sample_out_q   <= 8'sd0;
          sample_valid_q <= 1'b0;
          if (transfer) begin
            state_q        <= RUN;
            held_phase_q   <= phase_code;
            sym_cnt_q      <= 8'd0;
            sample_out_q   <= sample_d;
            sample_valid_q <= 1'b1;
            symbol_start_q <= 1'b1;
          end
        end
        default: begin
          if (sym_cnt_q != LAST_CNT) begin
            sym_cnt_q      <= sym_cnt_q + 8'd1;
            sample_out_q   <= sample_d;
            sample_valid_q <= 1'b1;
          end else if (transfer) begin
            held_phase_q   <= phase_code;
            sym_cnt_q      <= 8'd0;
            sample_out_q   <= sample_d;
            sample_valid_q <= 1'b1;
            symbol_start_q <= 1'b1;
          end else begin
            state_q        <= IDLE;
            sym_cnt_q      <= 8'd0;
            sample_out_q   <= 8'sd0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b1;
          end
        end
      endcase
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign symbol_start = symbol_start_q;
  assign underrun     = underrun_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/qpsk_wave_synth.md
# qpsk_wave_synth

Waveform synthesis stage directly downstream of the 16-way phase-code multiplexer in the QPSK modulator. It accepts one 4-bit phase code per symbol over a valid/ready handshake and holds that phase for a programmable number of samples. It outputs a signed 8-bit sampled carrier whose phase offset equals code × 22.5°. The carrier runs from a free-running 16-step reference counter, so phase relationships stay coherent across symbols.

## Interface
- SPS, default 16: samples per symbol; legal range 2..256.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- phase_code  input  4  phase code from the multiplexer; 0 = 0°, 15 = 337.5°, steps of 22.5°.
- phase_valid  input  1  phase_code is valid this cycle.
- phase_ready  output  1  block accepts a code this cycle; transfer when phase_valid && phase_ready.
- sample_out  output  8  signed two's-complement carrier sample (QPSK_wave bus).
- sample_valid  output  1  sample_out holds a symbol sample.
- symbol_start  output  1  one-cycle pulse with the first sample of each symbol.
- underrun  output  1  one-cycle pulse when a symbol ends with no next code available.

## Operation
- Reference counter carrier_idx (4 bits):
  - Cleared by reset; increments mod 16 on every clock edge with rst high, in every state.
  - Wraps 15 -> 0.
- Sine table: 16 entries, LUT[k] = round(127·sin(2πk/16)) = 0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49.
- Sample index = (carrier_idx + held_phase) mod 16, 4-bit wrap-around add.
  - carrier_idx is the value before that edge's increment.
- States:
  - IDLE: sample_out = 0, sample_valid = 0, phase_ready = 1.
  - RUN: emits samples and counts sym_cnt 0..SPS-1 (8 bits).
- Transitions:
  - IDLE -> RUN on transfer: held_phase <= phase_code, sym_cnt <= 0, symbol_start pulses.
  - RUN, sym_cnt < SPS-1: sym_cnt increments; held_phase is unchanged. phase_ready = 0.
  - RUN, sym_cnt = SPS-1: phase_ready = 1.
    - With a transfer: load the new code, sym_cnt <= 0, pulse symbol_start, stay in RUN. This is back-to-back, with no gap sample.
    - Without a transfer: go to IDLE, pulse underrun, sample_out <= 0.
- phase_ready is combinational from state and sym_cnt only. It must not depend on phase_valid.
- phase_code is ignored unless a transfer occurs.

## Timing
- Reset (rst low at an edge) forces on that edge:
  - sample_out = 0, sample_valid = 0, symbol_start = 0, underrun = 0.
  - state = IDLE, sym_cnt = 0, held_phase = 0, carrier_idx = 0.
- phase_ready = 1 while rst is low.
- Reset asserted mid-symbol aborts the symbol immediately. No underrun pulse is produced.
- Latency: a transfer at edge n gives the first sample of that symbol registered at edge n.
  - It is visible in the cycle after edge n and uses carrier_idx as sampled at edge n and the new code.
- Each symbol occupies exactly SPS consecutive sample_valid cycles.
- A code accepted at sym_cnt = SPS-1 takes effect on the very next sample.
- Throughput: one sample per clock; one code per SPS clocks when back-to-back.

## Test plan
- Reset then single symbol:
  - Stimulus: rst low 3 cycles, then high; phase_valid = 1, code 4 from the first rst-high edge; SPS = 16.
  - Response: first sample 127, then 117, 90, 49, 0, ... for 16 valid samples with symbol_start on the first.
- Back-to-back codes:
  - Stimulus: codes 0 then 8, valid continuously.
  - Response: sample 17 equals the negated LUT value of sample 1 position (phase inverted); no gap; symbol_start on samples 1 and 17.
- Underrun:
  - Stimulus: one code (2), then phase_valid = 0.
  - Response: after 16 samples, underrun pulses once, sample_out = 0, sample_valid = 0, phase_ready = 1.
- Wrap-around:
  - Stimulus: code 15 accepted with carrier_idx = 3.
  - Response: first sample LUT[2] = 90.
- Handshake stall:
  - Stimulus: phase_valid held high mid-symbol with a changing phase_code.
  - Response: phase_ready = 0, held phase unchanged, no transfer until sym_cnt = SPS-1.
- Mid-symbol reset:
  - Stimulus: rst low at sym_cnt = 7.
  - Response: all outputs at reset values the next cycle; no underrun pulse. The next accepted code with SPS = 2 yields exactly 2 samples.
